// File: rtl/regfile_write_scheduler.sv
// Write-port sequencer for the 32x32 register file: a clear sweep after reset,
// then round-robin arbitration between ALU (A) and load-unit (B) writebacks.
module regfile_write_scheduler #(
    parameter int NREG = 32,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            clearN,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [AW-1:0]   a_addr,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [AW-1:0]   b_addr,
    input  logic [XLEN-1:0] b_data,
    output logic [NREG-1:0] wr_en,
    output logic [NREG-1:0] wr_clr,
    output logic [XLEN-1:0] wr_data,
    output logic            wr_valid,
    output logic [AW-1:0]   wr_addr,
    output logic            init_done
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [NREG-1:0] ONE_HOT_0 = {{(NREG-1){1'b0}}, 1'b1};
    localparam logic [AW:0]     IDX_STEP  = {{AW{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [AW:0]     idx_q, idx_d;
    logic            rr_q, rr_d;
    logic [NREG-1:0] wr_en_q, wr_en_d;
    logic [NREG-1:0] wr_clr_q, wr_clr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic            wr_valid_q, wr_valid_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic            init_done_q, init_done_d;

    logic            grant_a, grant_b;
    logic [AW-1:0]   sel_addr;
    logic [XLEN-1:0] sel_data;
    logic [NREG-1:0] sweep_onehot;
    logic [NREG-1:0] sel_onehot;

    // rr_q = 0 favours A on a conflict, rr_q = 1 favours B.
    assign grant_a = (state_q == RUN) && a_valid && (!b_valid || !rr_q);
    assign grant_b = (state_q == RUN) && b_valid && (!a_valid ||  rr_q);

    assign sel_addr     = grant_a ? a_addr : b_addr;
    assign sel_data     = grant_a ? a_data : b_data;
    assign sweep_onehot = ONE_HOT_0 << idx_q[AW-1:0];
    assign sel_onehot   = ONE_HOT_0 << sel_addr;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rr_d        = rr_q;
        wr_en_d     = '0;
        wr_clr_d    = '0;
        wr_data_d   = '0;
        wr_valid_d  = 1'b0;
        wr_addr_d   = '0;
        init_done_d = init_done_q;

        unique case (state_q)
            INIT: begin
                // idx_q carries one extra bit so the cycle after the last clear is visible.
                if (!idx_q[AW]) begin
                    wr_en_d    = sweep_onehot;
                    wr_clr_d   = sweep_onehot;
                    wr_valid_d = 1'b1;
                    wr_addr_d  = idx_q[AW-1:0];
                    idx_d      = idx_q + IDX_STEP;
                end else begin
                    idx_d       = '0;
                    init_done_d = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (grant_a || grant_b) begin
                    wr_en_d    = (sel_addr != '0) ? sel_onehot : '0;
                    wr_valid_d = (sel_addr != '0);
                    wr_data_d  = sel_data;
                    wr_addr_d  = sel_addr;
                end
                if (a_valid && b_valid) begin
                    rr_d = grant_a;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge clearN) begin
        if (!clearN) begin
            state_q     <= INIT;
            idx_q       <= '0;
            rr_q        <= 1'b0;
            wr_en_q     <= '0;
            wr_clr_q    <= '0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            wr_en_q     <= wr_en_d;
            wr_clr_q    <= wr_clr_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            init_done_q <= init_done_d;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign wr_en     = wr_en_q;
    assign wr_clr    = wr_clr_q;
    assign wr_data   = wr_data_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: a cycle-count/grant model checked every
// falling edge, plus directed literal expectations after chosen rising edges.
module tb_regfile_write_scheduler;

    localparam int NREG = 32;

    logic        clk;
    logic        clearN;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic [31:0] wr_en, wr_clr, wr_data;
    logic        wr_valid;
    logic [4:0]  wr_addr;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    regfile_write_scheduler #(.NREG(32), .XLEN(32), .AW(5)) dut (
        .clk(clk), .clearN(clearN),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        .wr_en(wr_en), .wr_clr(wr_clr), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_addr(wr_addr), .init_done(init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: rising edges seen since clearN released, and whether B wins the next conflict.
    int          edges    = 0;
    logic        rrIsB    = 1'b0;
    logic [31:0] expEn    = 32'd0;
    logic [31:0] expClr   = 32'd0;
    logic [31:0] expData  = 32'd0;
    logic        expValid = 1'b0;
    logic [4:0]  expAddr  = 5'd0;
    logic        expInit  = 1'b0;

    function automatic logic modelGrantA();
        return a_valid && (!b_valid || !rrIsB);
    endfunction

    function automatic logic [4:0] winnerAddr();
        return modelGrantA() ? a_addr : b_addr;
    endfunction

    function automatic logic [31:0] winnerData();
        return modelGrantA() ? a_data : b_data;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                 input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_addr = aa; a_data = ad;
        b_valid = bv; b_addr = ba; b_data = bd;
    endtask

    task automatic waitEdges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk or negedge clearN) begin
        if (!clearN) begin
            edges    <= 0;
            rrIsB    <= 1'b0;
            expEn    <= 32'd0;
            expClr   <= 32'd0;
            expData  <= 32'd0;
            expValid <= 1'b0;
            expAddr  <= 5'd0;
            expInit  <= 1'b0;
        end else begin
            edges <= edges + 1;
            if (edges < NREG) begin
                expEn    <= 32'd1 << edges;
                expClr   <= 32'd1 << edges;
                expData  <= 32'd0;
                expValid <= 1'b1;
                expAddr  <= edges[4:0];
                expInit  <= 1'b0;
            end else begin
                expInit <= 1'b1;
                expClr  <= 32'd0;
                if (edges > NREG && (a_valid || b_valid)) begin
                    expEn    <= (winnerAddr() == 5'd0) ? 32'd0 : (32'd1 << winnerAddr());
                    expValid <= (winnerAddr() != 5'd0);
                    expAddr  <= winnerAddr();
                    expData  <= winnerData();
                    if (a_valid && b_valid) rrIsB <= modelGrantA();
                end else begin
                    expEn    <= 32'd0;
                    expValid <= 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        checkOutput("mdl.wr_en", wr_en, expEn);
        checkOutput("mdl.wr_clr", wr_clr, expClr);
        checkOutput("mdl.wr_valid", 32'(wr_valid), 32'(expValid));
        checkOutput("mdl.init_done", 32'(init_done), 32'(expInit));
        checkOutput("mdl.a_ready", 32'(a_ready), 32'(edges > NREG && modelGrantA()));
        checkOutput("mdl.b_ready", 32'(b_ready), 32'(edges > NREG && b_valid && !modelGrantA()));
        checkOutput("mdl.bothReady", 32'(a_ready & b_ready), 32'd0);
        if (expValid) begin
            checkOutput("mdl.wr_addr", 32'(wr_addr), 32'(expAddr));
            checkOutput("mdl.wr_data", wr_data, expData);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearN = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #2 clearN = 1'b0;
        #1;
        checkOutput("rst.wr_en", wr_en, 32'd0);
        checkOutput("rst.wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("rst.init_done", 32'(init_done), 32'd0);
        waitEdges(2);
        clearN = 1'b1;

        // Sweep with no requests.
        waitEdges(1);
        checkOutput("sweep0.wr_en", wr_en, 32'h0000_0001);
        checkOutput("sweep0.wr_clr", wr_clr, 32'h0000_0001);
        checkOutput("sweep0.wr_data", wr_data, 32'd0);
        checkOutput("sweep0.wr_addr", 32'(wr_addr), 32'd0);
        waitEdges(31);
        checkOutput("sweep31.wr_en", wr_en, 32'h8000_0000);
        checkOutput("sweep31.wr_addr", 32'(wr_addr), 32'd31);
        checkOutput("sweep31.init_done", 32'(init_done), 32'd0);
        waitEdges(1);
        checkOutput("edge33.init_done", 32'(init_done), 32'd1);
        checkOutput("edge33.wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("edge33.wr_clr", wr_clr, 32'd0);

        // Request held through a fresh sweep.
        clearN = 1'b0;
        #1;
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        #1;
        checkOutput("rstHold.a_ready", 32'(a_ready), 32'd0);
        waitEdges(1);
        clearN = 1'b1;
        for (int k = 1; k <= NREG; k++) begin
            waitEdges(1);
            checkOutput("initHold.a_ready", 32'(a_ready), 32'd0);
        end
        waitEdges(1);
        checkOutput("firstRun.a_ready", 32'(a_ready), 32'd1);
        waitEdges(1);
        checkOutput("held.wr_en", wr_en, 32'h0000_0020);
        checkOutput("held.wr_data", wr_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        waitEdges(1);
        checkOutput("heldOnce.wr_en", wr_en, 32'd0);
        checkOutput("heldOnce.wr_valid", 32'(wr_valid), 32'd0);

        // Continuous conflict alternates A, B, A, B.
        applyStimulus(1'b1, 5'd3, 32'hA0A0_A0A0, 1'b1, 5'd7, 32'hB0B0_B0B0);
        #1;
        checkOutput("conf.a_ready", 32'(a_ready), 32'd1);
        checkOutput("conf.b_ready", 32'(b_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            waitEdges(1);
            checkOutput("alt.wr_en", wr_en, (i % 2 == 0) ? 32'h0000_0008 : 32'h0000_0080);
            checkOutput("alt.wr_data", wr_data, (i % 2 == 0) ? 32'hA0A0_A0A0 : 32'hB0B0_B0B0);
            checkOutput("alt.a_ready", 32'(a_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

        // B alone to x0, then a conflict still favours A.
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234_5678);
        #1;
        checkOutput("x0.b_ready", 32'(b_ready), 32'd1);
        checkOutput("x0.a_ready", 32'(a_ready), 32'd0);
        waitEdges(1);
        checkOutput("x0.wr_en", wr_en, 32'd0);
        checkOutput("x0.wr_valid", 32'(wr_valid), 32'd0);
        applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
        #1;
        checkOutput("postX0.a_ready", 32'(a_ready), 32'd1);
        checkOutput("postX0.b_ready", 32'(b_ready), 32'd0);
        waitEdges(1);
        checkOutput("postX0.wr_en", wr_en, 32'h0000_0008);

        // Three back-to-back A writes to x9; single grants leave B favoured.
        applyStimulus(1'b1, 5'd9, 32'd1, 1'b0, 5'd0, 32'd0);
        for (int k = 1; k <= 3; k++) begin
            waitEdges(1);
            checkOutput("b2b.wr_en", wr_en, 32'h0000_0200);
            checkOutput("b2b.wr_data", wr_data, 32'(k));
            if (k < 3) applyStimulus(1'b1, 5'd9, 32'(k + 1), 1'b0, 5'd0, 32'd0);
            else       applyStimulus(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd7, 32'h0000_0077);
        end
        #1;
        checkOutput("rrKeep.b_ready", 32'(b_ready), 32'd1);
        checkOutput("rrKeep.a_ready", 32'(a_ready), 32'd0);
        waitEdges(1);
        checkOutput("rrKeep.wr_en", wr_en, 32'h0000_0080);

        // Reset while a write to x8 is on the port.
        applyStimulus(1'b1, 5'd8, 32'h0000_0100, 1'b0, 5'd0, 32'd0);
        waitEdges(1);
        checkOutput("pre.wr_en", wr_en, 32'h0000_0100);
        #2 clearN = 1'b0;
        #1;
        checkOutput("midRst.wr_en", wr_en, 32'd0);
        checkOutput("midRst.wr_valid", 32'(wr_valid), 32'd0);
        checkOutput("midRst.wr_data", wr_data, 32'd0);
        checkOutput("midRst.wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("midRst.init_done", 32'(init_done), 32'd0);
        checkOutput("midRst.a_ready", 32'(a_ready), 32'd0);
        waitEdges(1);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        clearN = 1'b1;
        waitEdges(1);
        checkOutput("resweep0.wr_en", wr_en, 32'h0000_0001);
        checkOutput("resweep0.wr_clr", wr_clr, 32'h0000_0001);
        waitEdges(31);
        checkOutput("resweep31.wr_en", wr_en, 32'h8000_0000);
        checkOutput("resweep31.init_done", 32'(init_done), 32'd0);
        waitEdges(1);
        checkOutput("reinit.init_done", 32'(init_done), 32'd1);
        checkOutput("reinit.wr_valid", 32'(wr_valid), 32'd0);
        waitEdges(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
